// File: rtl/dsp_pipelined_mac_if.sv
// dsp_pipelined_mac_if: bus bundle for dsp_pipelined_mac.
//   master : drives in_valid, a, b, m, acc_en, acc_clr; observes out, out_valid, overflow
//   slave  : the MAC side of the same signals
// a/b are DATA_WIDTH/2 bits wide, out is DATA_WIDTH bits wide.
interface dsp_pipelined_mac_if #(
    parameter int DATA_WIDTH = 4
);
    localparam int OW = DATA_WIDTH / 2;

    logic                  in_valid;
    logic [OW-1:0]         a;
    logic [OW-1:0]         b;
    logic                  m;
    logic                  acc_en;
    logic                  acc_clr;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_valid;
    logic                  overflow;

    modport master (
        output in_valid, a, b, m, acc_en, acc_clr,
        input  out, out_valid, overflow
    );

    modport slave (
        input  in_valid, a, b, m, acc_en, acc_clr,
        output out, out_valid, overflow
    );
endinterface

// File: rtl/dsp_pipelined_mac.sv
// dsp_pipelined_mac: unsigned multiply/add of two DATA_WIDTH/2-bit operands
// behind IN_STAGES input register stages (0..4), with a registered output
// and an optional accumulator.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears pipeline and output state
//   bus  : dsp_pipelined_mac_if.slave
//          in_valid/a/b/m/acc_en travel together through the pipeline;
//          acc_clr bypasses it and acts on the next edge;
//          out/out_valid/overflow are registered.
// Build option: define DSP_PIPELINED_MAC_ACC_EN to build the accumulator
// (acc_en, acc_clr, sticky overflow). Without it, out loads R on every valid
// slot and overflow is tied low.
module dsp_pipelined_mac #(
    parameter int DATA_WIDTH = 4,
    parameter int IN_STAGES  = 1
) (
    input logic                 clk,
    input logic                 rst,
    dsp_pipelined_mac_if.slave  bus
);
    localparam int OW = DATA_WIDTH / 2;

    // One pipeline slot's payload; valid is carried separately in vld_pipe.
    typedef struct packed {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic          m;
`ifdef DSP_PIPELINED_MAC_ACC_EN
        logic          acc_en;
`endif
    } slot_t;

    slot_t in_dat;
    slot_t s_dat;    // last stage (or raw inputs at depth 0)
    logic  s_vld;

    always_comb begin
        in_dat   = '0;
        in_dat.a = bus.a;
        in_dat.b = bus.b;
        in_dat.m = bus.m;
`ifdef DSP_PIPELINED_MAC_ACC_EN
        in_dat.acc_en = bus.acc_en;
`endif
    end

    generate
        if (IN_STAGES == 0) begin : g_comb
            assign s_vld = bus.in_valid;
            assign s_dat = in_dat;
        end else begin : g_pipe
            logic [IN_STAGES:1] vld_pipe;
            slot_t              dat_pipe [IN_STAGES:1];

            // Stages always advance; reset flushes valid and data alike.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe <= '0;
                    for (int k = 1; k <= IN_STAGES; k++) dat_pipe[k] <= '0;
                end else begin
                    vld_pipe[1] <= bus.in_valid;
                    dat_pipe[1] <= in_dat;
                    for (int k = 2; k <= IN_STAGES; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        dat_pipe[k] <= dat_pipe[k-1];
                    end
                end
            end

            assign s_vld = vld_pipe[IN_STAGES];
            assign s_dat = dat_pipe[IN_STAGES];
        end
    endgenerate

    // Product fits DATA_WIDTH exactly; the sum needs OW+1 bits and is
    // zero-extended by the cast.
    logic [DATA_WIDTH-1:0] r;
    always_comb begin
        r = s_dat.m ? DATA_WIDTH'(s_dat.a) * DATA_WIDTH'(s_dat.b)
                    : DATA_WIDTH'(s_dat.a) + DATA_WIDTH'(s_dat.b);
    end

    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid_q;

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

`ifdef DSP_PIPELINED_MAC_ACC_EN
    logic                  ovf_q;
    logic [DATA_WIDTH-1:0] acc_base;
    logic                  ovf_base;
    logic [DATA_WIDTH:0]   acc_sum;

    // acc_clr is not pipelined: a clear landing with an accumulate makes
    // the accumulator start from zero for that same result.
    always_comb begin
        acc_base = bus.acc_clr ? '0   : out_q;
        ovf_base = bus.acc_clr ? 1'b0 : ovf_q;
        acc_sum  = {1'b0, acc_base} + {1'b0, r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (s_vld) begin
            out_valid_q <= 1'b1;
            if (s_dat.acc_en) begin
                out_q <= acc_sum[DATA_WIDTH-1:0];
                ovf_q <= ovf_base | acc_sum[DATA_WIDTH];
            end else begin
                out_q <= r;
                ovf_q <= ovf_base;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (bus.acc_clr) begin
                out_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.overflow = ovf_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= s_vld;
            if (s_vld) out_q <= r;
        end
    end

    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_dsp_pipelined_mac.sv
module tb_dsp_pipelined_mac;
`ifdef DSP_PIPELINED_MAC_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    typedef struct {
        logic [3:0] o;
        logic       v;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1, rst4;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q0[$], q1[$], q4[$];
    exp_t e0, e1, e4;

    dsp_pipelined_mac_if #(.DATA_WIDTH(4)) if0 ();
    dsp_pipelined_mac_if #(.DATA_WIDTH(4)) if1 ();
    dsp_pipelined_mac_if #(.DATA_WIDTH(4)) if4 ();

    dsp_pipelined_mac #(.DATA_WIDTH(4), .IN_STAGES(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
    dsp_pipelined_mac #(.DATA_WIDTH(4), .IN_STAGES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    dsp_pipelined_mac #(.DATA_WIDTH(4), .IN_STAGES(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endfunction

    // Scoreboard monitors: every out_valid pulse must match the oldest
    // expectation, including the edge it was due on.
    always @(negedge clk) if (if0.out_valid) begin
        if (q0.size() == 0) chk("dut0 unexpected out_valid", 1, 0);
        else begin
            e0 = q0.pop_front();
            chk("dut0 out", 32'(if0.out), 32'(e0.o));
            chk("dut0 overflow", 32'(if0.overflow), 32'(e0.v));
            chk("dut0 latency", cyc, e0.c);
        end
    end
    always @(negedge clk) if (if1.out_valid) begin
        if (q1.size() == 0) chk("dut1 unexpected out_valid", 1, 0);
        else begin
            e1 = q1.pop_front();
            chk("dut1 out", 32'(if1.out), 32'(e1.o));
            chk("dut1 overflow", 32'(if1.overflow), 32'(e1.v));
            chk("dut1 latency", cyc, e1.c);
        end
    end
    always @(negedge clk) if (if4.out_valid) begin
        if (q4.size() == 0) chk("dut4 unexpected out_valid", 1, 0);
        else begin
            e4 = q4.pop_front();
            chk("dut4 out", 32'(if4.out), 32'(e4.o));
            chk("dut4 overflow", 32'(if4.overflow), 32'(e4.v));
            chk("dut4 latency", cyc, e4.c);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One valid slot. dut1 always receives it (with acc_en); dut0/dut4 only
    // when 'all' is set, and they never accumulate.
    task automatic issue(input bit all, input logic [1:0] ia, input logic [1:0] ib,
                         input logic im, input logic ie,
                         input logic [3:0] eo, input logic ev);
        if0.a = ia; if0.b = ib; if0.m = im; if0.in_valid = all;
        if4.a = ia; if4.b = ib; if4.m = im; if4.in_valid = all;
        if1.a = ia; if1.b = ib; if1.m = im; if1.in_valid = 1'b1; if1.acc_en = ie;
        q1.push_back('{eo, ev, cyc + 2});
        if (all) begin
            q0.push_back('{eo, 1'b0, cyc + 1});
            q4.push_back('{eo, 1'b0, cyc + 5});
        end
        tick();
        if0.in_valid = 1'b0; if1.in_valid = 1'b0; if4.in_valid = 1'b0;
        if1.acc_en = 1'b0;
    endtask

    task automatic chk_idle(input logic [3:0] o1);
        chk("dut0 idle out", 32'(if0.out), 0);
        chk("dut0 idle overflow", 32'(if0.overflow), 0);
        chk("dut0 idle out_valid", 32'(if0.out_valid), 0);
        chk("dut1 idle out", 32'(if1.out), 32'(o1));
        chk("dut1 idle overflow", 32'(if1.overflow), 0);
        chk("dut1 idle out_valid", 32'(if1.out_valid), 0);
        chk("dut4 idle out", 32'(if4.out), 0);
        chk("dut4 idle overflow", 32'(if4.overflow), 0);
        chk("dut4 idle out_valid", 32'(if4.out_valid), 0);
    endtask

    initial begin
        {if0.in_valid, if0.a, if0.b, if0.m, if0.acc_en, if0.acc_clr} = '0;
        {if1.in_valid, if1.a, if1.b, if1.m, if1.acc_en, if1.acc_clr} = '0;
        {if4.in_valid, if4.a, if4.b, if4.m, if4.acc_en, if4.acc_clr} = '0;
        rst0 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
        idle(2);
        rst0 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;

        // Reset state, then an input accepted on the first cycle out of reset.
        chk_idle(4'd0);
        issue(1, 2'd3, 2'd2, 1'b1, 1'b0, 4'd6, 1'b0);
        idle(6);
        chk("dut0 hold 6", 32'(if0.out), 6);
        chk("dut1 hold 6", 32'(if1.out), 6);
        chk("dut4 hold 6", 32'(if4.out), 6);
        chk("dut1 hold out_valid", 32'(if1.out_valid), 0);

        // Mode select travels with its operands.
        issue(1, 2'd3, 2'd3, 1'b0, 1'b0, 4'd6, 1'b0);
        issue(1, 2'd3, 2'd3, 1'b1, 1'b0, 4'd9, 1'b0);
        idle(6);

        // Accumulate chain with wrap and sticky overflow (dut1).
        if1.acc_clr = 1'b1;
        tick();
        if1.acc_clr = 1'b0;
        issue(0, 2'd3, 2'd3, 1'b1, 1'b1, 4'd9, 1'b0);
        issue(0, 2'd3, 2'd3, 1'b1, 1'b1, ACC ? 4'd2 : 4'd9, ACC);
        issue(0, 2'd3, 2'd3, 1'b1, 1'b1, ACC ? 4'd11 : 4'd9, ACC);
        idle(3);
        chk("dut1 overflow sticky", 32'(if1.overflow), 32'(ACC));
        if1.acc_clr = 1'b1;
        tick();
        if1.acc_clr = 1'b0;
        chk("dut1 clr out", 32'(if1.out), ACC ? 0 : 9);
        chk("dut1 clr overflow", 32'(if1.overflow), 0);
        chk("dut1 clr out_valid", 32'(if1.out_valid), 0);

        // Build accumulator to 7, then clear coinciding with an accumulate.
        issue(0, 2'd3, 2'd1, 1'b0, 1'b0, 4'd4, 1'b0);
        issue(0, 2'd1, 2'd2, 1'b0, 1'b1, ACC ? 4'd7 : 4'd3, 1'b0);
        issue(0, 2'd2, 2'd2, 1'b1, 1'b1, 4'd4, 1'b0);
        if1.acc_clr = 1'b1;
        tick();
        if1.acc_clr = 1'b0;
        idle(2);
        chk("dut1 clr+acc out", 32'(if1.out), 4);
        chk("dut1 clr+acc overflow", 32'(if1.overflow), 0);

        // Reset discards in-flight work: dut0 reset on the sampling edge,
        // dut1/dut4 one edge later, before their results emerge.
        if0.a = 2'd1; if0.b = 2'd1; if0.m = 1'b1; if0.in_valid = 1'b1;
        if1.a = 2'd1; if1.b = 2'd1; if1.m = 1'b1; if1.in_valid = 1'b1;
        if4.a = 2'd1; if4.b = 2'd1; if4.m = 1'b1; if4.in_valid = 1'b1;
        rst0 = 1'b1;
        tick();
        if0.in_valid = 1'b0; if1.in_valid = 1'b0; if4.in_valid = 1'b0;
        rst0 = 1'b0; rst1 = 1'b1; rst4 = 1'b1;
        tick();
        rst1 = 1'b0; rst4 = 1'b0;
        chk_idle(4'd0);
        idle(7);
        chk("dut0 after rst out", 32'(if0.out), 0);
        chk("dut4 after rst out", 32'(if4.out), 0);

        // Latencies 1/2/5 after reset.
        issue(1, 2'd1, 2'd1, 1'b1, 1'b0, 4'd1, 1'b0);
        idle(7);

        chk("dut0 scoreboard drained", q0.size(), 0);
        chk("dut1 scoreboard drained", q1.size(), 0);
        chk("dut4 scoreboard drained", q4.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsp_pipelined_mac.md
# dsp_pipelined_mac

Parametrised DSP block: unsigned multiply/add of two half-width operands, with a configurable-depth input register pipeline on all operands and sideband, a registered output, and an optional accumulator. It generalises the single-stage, partially registered DSP. It sits in the DSP test hierarchy as the packable, fully pipelined variant. All inputs, including the mode select, travel through the same register stages, so results stay aligned at any depth.

## Interface
- `DATA_WIDTH`, default 4: result width. Operands are `DATA_WIDTH/2` bits wide. Must be even and ≥2.
- `IN_STAGES`, default 1: number of input register stages, legal range 0..4.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `in_valid`  in  1  qualifies `a`, `b`, `m` and `acc_en` this cycle.
- `a`  in  DATA_WIDTH/2  operand A, unsigned.
- `b`  in  DATA_WIDTH/2  operand B, unsigned.
- `m`  in  1  mode select: 1 = multiply, 0 = add.
- `acc_en`  in  1  1 = add result into accumulator; 0 = load result.
- `acc_clr`  in  1  clears accumulator. Not pipelined.
- `out`  out  DATA_WIDTH  registered result or accumulator value.
- `out_valid`  out  1  `out` updated on this edge.
- `overflow`  out  1  sticky accumulator carry-out.

## Operation
- Sideband and data move together. `{in_valid, a, b, m, acc_en}` shift through `IN_STAGES` register stages. Stages always advance; there is no stall.
- Stage output S is the last stage, or the raw inputs when `IN_STAGES`=0. Combinational result R is computed from S:
  - m=1: R = a*b, full `DATA_WIDTH` bits.
  - m=0: R = a+b, `DATA_WIDTH/2+1` bits, zero-extended to `DATA_WIDTH`.
- Output register update, in priority order:
  - `rst`: out=0, out_valid=0, overflow=0.
  - S.valid=1 and S.acc_en=1: {carry, out} ← base + R, where base = 0 if `acc_clr`=1, else `out`. Wraps modulo 2^DATA_WIDTH. overflow ← (`acc_clr` ? 0 : overflow) | carry. out_valid=1.
  - S.valid=1 and S.acc_en=0: out ← R. overflow ← `acc_clr` ? 0 : overflow. out_valid=1.
  - S.valid=0 and `acc_clr`=1: out=0, overflow=0, out_valid=0.
  - S.valid=0 otherwise: out and overflow hold; out_valid=0.
- Invalid slots (bubbles) never modify `out`. Data in invalid slots is don't-care.
- Reset clears every pipeline stage, both valid and data bits. Transactions in flight at reset are discarded and produce no `out_valid`.

## Timing
- Latency from `in_valid` to `out_valid`: IN_STAGES+1 cycles. At IN_STAGES=0, `out` updates on the edge that samples `in_valid`.
- Throughput: one transaction per cycle. Back-to-back accumulates chain with no bubble needed.
- `out_valid` is a single-cycle pulse per transaction. `out` holds its value afterward.
- `acc_clr` acts on the next edge, independent of pipeline depth. When it coincides with an arriving accumulate, the result is the new accumulator value, i.e. 0 + R.
- First cycle after `rst` deasserts: out=0, out_valid=0, overflow=0. An input accepted on that cycle emerges IN_STAGES+1 edges later.

## Configuration
- `DSP_PIPELINED_MAC_ACC_EN` defined: accumulator, `acc_en`, `acc_clr` and `overflow` behave as specified above.
- Not defined:
  - `out` ← R on every valid slot.
  - `acc_en` and `acc_clr` are ignored, and the `acc_en` pipeline bit is not built.
  - `overflow` is tied to 0.
  - Latency and `out_valid` timing are unchanged.

## Test plan
- DATA_WIDTH=4, IN_STAGES=1. a=3, b=2, m=1, acc_en=0, one cycle valid → out=6, out_valid=1 exactly 2 edges later. out holds 6 afterward with out_valid=0.
- a=3, b=3, m=0, then a=3, b=3, m=1, back-to-back → out=6, then 9 on consecutive cycles. Verifies mode alignment through the pipeline.
- Macro defined: three valid a=3, b=3, m=1 with acc_en=1, starting after `acc_clr` → out=9, 2, 11; overflow rises with the second result and stays 1. `acc_clr` alone then gives out=0, overflow=0.
- `acc_clr`=1 on the same cycle an acc_en=1 result a=2, b=2, m=1 arrives, with accumulator at 7 → out=4, overflow=0.
- Issue a=1, b=1, m=1 valid, then assert `rst` for one cycle before it emerges → no out_valid pulse; out=0. Repeat at IN_STAGES=0 and IN_STAGES=4 to confirm latencies of 1 and 5.
- Macro undefined: same stimulus as the accumulate test → out=9, 9, 9; overflow stays 0.
